// File: rtl/bus_cycle_sequencer.sv
// 68000 bus cycle sequencer: decodes A[23:20] into chip selects, inserts per-region
// wait states before DTACK, and raises BERR on unmapped accesses, ROM writes and timeouts.
module bus_cycle_sequencer #(
  parameter logic [3:0] ROM_BASE     = 4'h0,
  parameter logic [3:0] RAM_BASE     = 4'h1,
  parameter logic [3:0] IO_BASE      = 4'hF,
  parameter int         ROM_WAIT     = 2,
  parameter int         RAM_WAIT     = 0,
  parameter int         IO_WAIT      = 4,
  parameter int         BERR_TIMEOUT = 64
) (
  input  logic       CPUCLK_IN,
  input  logic       RESET_IN,
  input  logic       RUN_IN,
  input  logic       AS_IN,
  input  logic       UDS_IN,
  input  logic       LDS_IN,
  input  logic       RW_IN,
  input  logic [3:0] ADDR_IN,
  output logic       ROM_CS,
  output logic       RAM_CS,
  output logic       IO_CS,
  output logic       DTACK,
  output logic       BERR,
  output logic       BUSY
);

  localparam logic [7:0] ROM_W  = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_W  = 8'(RAM_WAIT);
  localparam logic [7:0] IO_W   = 8'(IO_WAIT);
  localparam logic [7:0] TO_CNT = 8'(BERR_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, ACK, ERR, RELEASE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] cs_q, cs_nxt;          // {io, ram, rom}
  logic       dtack_q, dtack_nxt;
  logic       berr_q, berr_nxt;
  logic       busy_q;
  logic       mapped_q, mapped_nxt;
  logic       armed, armed_nxt;      // AS seen low since the last accepted cycle or reset
  logic       req;
  logic       hit_rom, hit_ram, hit_io;
  logic [7:0] w;

  // ROM > RAM > IO when bases collide
  assign hit_rom = (ADDR_IN == ROM_BASE);
  assign hit_ram = !hit_rom && (ADDR_IN == RAM_BASE);
  assign hit_io  = !hit_rom && !hit_ram && (ADDR_IN == IO_BASE);
  assign w       = hit_rom ? ROM_W : (hit_ram ? RAM_W : IO_W);
  assign req     = RUN_IN & AS_IN & (UDS_IN | LDS_IN) & armed;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cs_nxt     = cs_q;
    dtack_nxt  = dtack_q;
    berr_nxt   = berr_q;
    mapped_nxt = mapped_q;
    armed_nxt  = armed | ~AS_IN;
    case (state)
      IDLE: begin
        cs_nxt    = '0;
        dtack_nxt = 1'b0;
        berr_nxt  = 1'b0;
        if (req) begin
          armed_nxt = 1'b0;
          if (hit_rom && !RW_IN) begin
            state_nxt = ERR;
          end else if (hit_rom || hit_ram || hit_io) begin
            cs_nxt     = {hit_io, hit_ram, hit_rom};
            mapped_nxt = 1'b1;
            if (w == 8'd0) begin
              state_nxt = ACK;
              dtack_nxt = 1'b1;
            end else begin
              cnt_nxt   = w - 8'd1;
              state_nxt = WAIT;
            end
          end else begin
            mapped_nxt = 1'b0;
            cnt_nxt    = TO_CNT;
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (!AS_IN) begin
          state_nxt = RELEASE;
          cs_nxt    = '0;
        end else if (cnt == 8'd0) begin
          if (mapped_q) begin
            state_nxt = ACK;
            dtack_nxt = 1'b1;
          end else begin
            state_nxt = ERR;
            berr_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ACK, ERR: begin
        // ERR entered straight from IDLE (ROM write) raises BERR one edge later
        if (state == ERR) berr_nxt = 1'b1;
        if (!AS_IN) begin
          state_nxt = RELEASE;
          cs_nxt    = '0;
          dtack_nxt = 1'b0;
          berr_nxt  = 1'b0;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        cs_nxt    = '0;
        dtack_nxt = 1'b0;
        berr_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        cs_nxt    = '0;
        dtack_nxt = 1'b0;
        berr_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CPUCLK_IN) begin
    if (RESET_IN) begin
      state    <= IDLE;
      cnt      <= '0;
      cs_q     <= '0;
      dtack_q  <= 1'b0;
      berr_q   <= 1'b0;
      busy_q   <= 1'b0;
      mapped_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cs_q     <= cs_nxt;
      dtack_q  <= dtack_nxt;
      berr_q   <= berr_nxt;
      busy_q   <= (state_nxt != IDLE);
      mapped_q <= mapped_nxt;
      armed    <= armed_nxt;
    end
  end

  assign ROM_CS = cs_q[0];
  assign RAM_CS = cs_q[1];
  assign IO_CS  = cs_q[2];
  assign DTACK  = dtack_q;
  assign BERR   = berr_q;
  assign BUSY   = busy_q;

endmodule
